// File: rtl/border_bar_generator.sv
// Border-bar colour generator: per-channel free-running period counters step
// border levels (bars / ramp / off); pixels inside the screen window get a
// fixed paper colour. All outputs are registered with one cycle of latency.
module border_bar_generator #(
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned COLOR_WIDTH   = 8,
  parameter int unsigned COORD_WIDTH   = 9,
  parameter int unsigned COUNTER_WIDTH = 16,
  parameter logic [CHANNELS*COUNTER_WIDTH-1:0] PERIOD_INIT =
    {16'd19900, 16'd19920, 16'd19940},
  parameter int unsigned SCREEN_X0     = 48,
  parameter int unsigned SCREEN_X1     = 304,
  parameter int unsigned SCREEN_Y0     = 48,
  parameter int unsigned SCREEN_Y1     = 240,
  parameter logic [COLOR_WIDTH-1:0] PAPER = 8'hDD,
  localparam int unsigned SEL_WIDTH    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [COORD_WIDTH-1:0]          video_x,
  input  logic [COORD_WIDTH-1:0]          video_y,
  input  logic [1:0]                      mode,
  input  logic                            freeze,
  input  logic                            period_wr_en,
  input  logic [SEL_WIDTH-1:0]            period_wr_ch,
  input  logic [COUNTER_WIDTH-1:0]        period_wr_data,
  output logic [CHANNELS*COLOR_WIDTH-1:0] pixel,
  output logic                            in_screen,
  output logic [CHANNELS-1:0]             wrap
);

  localparam logic [1:0] MODE_RAMP = 2'd1;
  localparam logic [1:0] MODE_OFF  = 2'd2;

  localparam logic [COORD_WIDTH-1:0] X0 = COORD_WIDTH'(SCREEN_X0);
  localparam logic [COORD_WIDTH-1:0] X1 = COORD_WIDTH'(SCREEN_X1);
  localparam logic [COORD_WIDTH-1:0] Y0 = COORD_WIDTH'(SCREEN_Y0);
  localparam logic [COORD_WIDTH-1:0] Y1 = COORD_WIDTH'(SCREEN_Y1);

  logic [COUNTER_WIDTH-1:0] counter_q [CHANNELS];
  logic [COUNTER_WIDTH-1:0] period_q  [CHANNELS];
  logic [COLOR_WIDTH-1:0]   level_q   [CHANNELS];

  logic                            win_c;
  logic [CHANNELS*COLOR_WIDTH-1:0] pixel_next_c;

  // Next border level on a counter wrap for the current mode.
  function automatic logic [COLOR_WIDTH-1:0] step_level(
    input logic [COLOR_WIDTH-1:0] level,
    input logic [1:0]             md
  );
    logic [COLOR_WIDTH-1:0] nxt;
    nxt = level;
    if (md == MODE_RAMP) begin
      nxt = level + COLOR_WIDTH'(1);
    end else if (md != MODE_OFF) begin
      nxt = (level == '0) ? '1 : '0;
    end
    return nxt;
  endfunction

  // Screen window decode on the live beam coordinates.
  always_comb begin
    win_c = (video_x >= X0) && (video_x < X1) && (video_y >= Y0) && (video_y < Y1);
  end

  // Colour selection per channel, using levels before this edge's update.
  always_comb begin
    pixel_next_c = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (win_c) begin
        pixel_next_c[ch*COLOR_WIDTH +: COLOR_WIDTH] = PAPER;
      end else if (mode == MODE_OFF) begin
        pixel_next_c[ch*COLOR_WIDTH +: COLOR_WIDTH] = '0;
      end else begin
        pixel_next_c[ch*COLOR_WIDTH +: COLOR_WIDTH] = level_q[ch];
      end
    end
  end

  // Period registers, counters, levels and wrap pulses; wrap compare uses the old period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        counter_q[ch] <= '0;
        level_q[ch]   <= '0;
        period_q[ch]  <= PERIOD_INIT[ch*COUNTER_WIDTH +: COUNTER_WIDTH];
      end
      wrap <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (period_wr_en && (period_wr_ch == SEL_WIDTH'(ch))) begin
          period_q[ch] <= period_wr_data;
        end
        if (freeze) begin
          wrap[ch] <= 1'b0;
        end else if (counter_q[ch] >= period_q[ch]) begin
          counter_q[ch] <= '0;
          wrap[ch]      <= 1'b1;
          level_q[ch]   <= step_level(level_q[ch], mode);
        end else begin
          counter_q[ch] <= counter_q[ch] + COUNTER_WIDTH'(1);
          wrap[ch]      <= 1'b0;
        end
      end
    end
  end

  // Registered output stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel     <= '0;
      in_screen <= 1'b0;
    end else begin
      pixel     <= pixel_next_c;
      in_screen <= win_c;
    end
  end

endmodule

// File: tb/tb_border_bar_generator.sv
// Directed bench for border_bar_generator with hand-computed expectations.
module tb_border_bar_generator;

  logic        clock;
  logic        reset_n;
  logic [8:0]  video_x;
  logic [8:0]  video_y;
  logic [1:0]  mode;
  logic        freeze;
  logic        period_wr_en;
  logic [1:0]  period_wr_ch;
  logic [15:0] period_wr_data;
  logic [23:0] pixel;
  logic        in_screen;
  logic [2:0]  wrap;

  int checks = 0;
  int errors = 0;

  border_bar_generator dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .video_x        (video_x),
    .video_y        (video_y),
    .mode           (mode),
    .freeze         (freeze),
    .period_wr_en   (period_wr_en),
    .period_wr_ch   (period_wr_ch),
    .period_wr_data (period_wr_data),
    .pixel          (pixel),
    .in_screen      (in_screen),
    .wrap           (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset with idle inputs; the next rising edge after return is edge 1.
  task automatic do_reset();
    reset_n        = 1'b0;
    video_x        = 9'd0;
    video_y        = 9'd0;
    mode           = 2'd0;
    freeze         = 1'b0;
    period_wr_en   = 1'b0;
    period_wr_ch   = 2'd0;
    period_wr_data = 16'd0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic write_period(input logic [1:0] ch, input logic [15:0] data);
    period_wr_en   = 1'b1;
    period_wr_ch   = ch;
    period_wr_data = data;
  endtask

  // Run from reset release and record first wrap edge per channel plus pixel at edge 19941.
  task automatic first_wraps(output int f0, output int f1, output int f2, output logic [23:0] pix);
    f0 = 0; f1 = 0; f2 = 0; pix = '0;
    for (int n = 1; n <= 19960; n++) begin
      tick();
      if (wrap[0] && f0 == 0) f0 = n;
      if (wrap[1] && f1 == 0) f1 = n;
      if (wrap[2] && f2 == 0) f2 = n;
      if (n == 19941) pix = pixel;
    end
  endtask

  initial begin
    int f0, f1, f2;
    logic [23:0] pix;
    logic [7:0] lvl;
    logic [8:0] wx [8];
    logic [8:0] wy [8];
    logic       wexp [8];

    // 1. Reset values and power-on period timing.
    do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_pixel", 32'(pixel), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_in_screen", 32'(in_screen), 32'h0);
    tick();
    reset_n = 1'b1;
    first_wraps(f0, f1, f2, pix);
    check("t1_first_wrap0", 32'(f0), 32'd19941);
    check("t1_first_wrap1", 32'(f1), 32'd19921);
    check("t1_first_wrap2", 32'(f2), 32'd19901);
    check("t1_pixel_19941", 32'(pix), 32'hFFFF00);

    // 2. ch1 period 3 in bars mode: wrap every 4 edges, green toggles, pixel lags.
    do_reset();
    write_period(2'd1, 16'd3);
    lvl = 8'h00;
    for (int n = 1; n <= 12; n++) begin
      tick();
      period_wr_en = 1'b0;
      check("t2_wrap", 32'(wrap), (n % 4 == 0) ? 32'h2 : 32'h0);
      check("t2_green", 32'(pixel[15:8]), 32'(lvl));
      check("t2_red_blue", 32'({pixel[23:16], pixel[7:0]}), 32'h0);
      if (n % 4 == 0) lvl = ~lvl;
    end

    // 3. Ignored out-of-range write, then shrink ch0 period below its counter.
    do_reset();
    repeat (100) tick();
    write_period(2'd3, 16'd0);
    tick();
    period_wr_en = 1'b0;
    tick();
    check("t3_bad_ch_ignored", 32'(wrap), 32'h0);
    write_period(2'd0, 16'd10);
    tick();
    period_wr_en = 1'b0;
    check("t3_write_edge", 32'(wrap[0]), 32'h0);
    tick();
    check("t3_next_wrap", 32'(wrap[0]), 32'h1);
    for (int k = 1; k <= 22; k++) begin
      tick();
      check("t3_period11", 32'(wrap[0]), (k == 11 || k == 22) ? 32'h1 : 32'h0);
    end

    // 4. Window edges with border level 0.
    do_reset();
    wx = '{9'd47, 9'd48, 9'd303, 9'd304, 9'd100, 9'd100, 9'd100, 9'd100};
    wy = '{9'd100, 9'd100, 9'd100, 9'd100, 9'd47, 9'd48, 9'd239, 9'd240};
    wexp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      video_x = wx[i];
      video_y = wy[i];
      tick();
      check("t4_in_screen", 32'(in_screen), 32'(wexp[i]));
      check("t4_pixel", 32'(pixel), wexp[i] ? 32'hDDDDDD : 32'h0);
    end

    // 5. Ramp on ch2 with period 0, then freeze, then off mode.
    do_reset();
    mode = 2'd1;
    write_period(2'd2, 16'd0);
    for (int n = 1; n <= 258; n++) begin
      tick();
      period_wr_en = 1'b0;
      check("t5_blue_ramp", 32'(pixel[23:16]), (n >= 2) ? 32'((n - 2) % 256) : 32'h0);
      check("t5_wrap2", 32'(wrap[2]), (n >= 2) ? 32'h1 : 32'h0);
    end
    freeze = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("t5_freeze_wrap", 32'(wrap), 32'h0);
      check("t5_freeze_blue", 32'(pixel[23:16]), 32'h1);
    end
    freeze = 1'b0;
    tick();
    check("t5_unfreeze_wrap", 32'(wrap[2]), 32'h1);
    check("t5_unfreeze_blue", 32'(pixel[23:16]), 32'h1);
    tick();
    check("t5_resume_blue", 32'(pixel[23:16]), 32'h2);
    mode = 2'd2;
    tick();
    check("t5_off_pixel", 32'(pixel), 32'h0);

    // 6. Period write coinciding with a wrap; then reset mid-ramp.
    do_reset();
    write_period(2'd0, 16'd3);
    tick();
    period_wr_en = 1'b0;
    tick();
    tick();
    write_period(2'd0, 16'd5);
    tick();
    period_wr_en = 1'b0;
    check("t6_wrap_old_period", 32'(wrap[0]), 32'h1);
    for (int n = 5; n <= 11; n++) begin
      tick();
      check("t6_new_interval", 32'(wrap[0]), (n == 10) ? 32'h1 : 32'h0);
    end

    do_reset();
    mode = 2'd1;
    write_period(2'd2, 16'd0);
    repeat (6) begin
      tick();
      period_wr_en = 1'b0;
    end
    check("t6_ramp_before_reset", 32'(pixel[23:16]), 32'h4);
    reset_n = 1'b0;
    #1;
    check("t6_async_pixel", 32'(pixel), 32'h0);
    check("t6_async_wrap", 32'(wrap), 32'h0);
    tick();
    reset_n = 1'b1;
    mode = 2'd0;
    first_wraps(f0, f1, f2, pix);
    check("t6_init_wrap2", 32'(f2), 32'd19901);
    check("t6_init_wrap0", 32'(f0), 32'd19941);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
